// File: rtl/display_pkg.sv
// Shared constants, snapshot payload and nibble helper for the display scan path.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned VALUE_W    = NUM_DIGITS * NIB_W;
  localparam int unsigned IDX_W      = 2;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF      = 4'b1111;
  localparam bit                    SEG_ACTIVE_LOW = 1'b1;

  // One frame's worth of display content, captured atomically at frame end
  typedef struct packed {
    logic [VALUE_W-1:0]    value;
    logic [NUM_DIGITS-1:0] point;
    logic                  lz;
  } snap_t;

  // Select hex digit idx (digit 0 is the least-significant nibble)
  function automatic logic [NIB_W-1:0] nibble_sel(input logic [VALUE_W-1:0] value,
                                                  input logic [IDX_W-1:0]   idx);
    return value[{idx, 2'b00} +: NIB_W];
  endfunction

endpackage

// File: rtl/display_refresh_counter.sv
// Free-running slot counter: counts 0..REFRESH_DIV-1 and strobes on the last cycle.
module display_refresh_counter #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_slot_end_c
);

  logic [CNT_W-1:0] r_cnt;

  assign o_slot_end_c = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign o_cnt        = r_cnt;

  // Slot counter with wrap at the end of each slot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (o_slot_end_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Scans a snapshotted 4-digit hex value onto one shared decoder with guard time
// between digits and optional leading-zero blanking.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  input  logic [NUM_DIGITS-1:0] point_mask,
  input  logic                  lz_blank,
  output logic [NIB_W-1:0]      data,
  output logic                  point,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0]      w_cnt;
  logic                  w_slot_end;
  logic                  w_guard;
  logic                  w_blank;
  logic [VALUE_W-1:0]    w_upper;
  logic [NIB_W-1:0]      w_data;
  logic                  w_point;
  logic [NUM_DIGITS-1:0] w_an;

  logic [IDX_W-1:0]      r_idx;
  snap_t                 r_snap;
  logic [NIB_W-1:0]      r_data;
  logic                  r_point;
  logic [NUM_DIGITS-1:0] r_an;

  display_refresh_counter #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) u_refresh_counter (
    .clk          (clk),
    .rst          (rst),
    .o_cnt        (w_cnt),
    .o_slot_end_c (w_slot_end)
  );

  // Guard phase; with no guard time the digit is enabled for the whole slot
  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign w_guard = 1'b0;
    end else begin : g_guard
      assign w_guard = (w_cnt < CNT_W'(GUARD_CYCLES));
    end
  endgenerate

  // Digit index advances once per slot and wraps 3 -> 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  // Capture inputs on the last cycle of a frame so a frame is never torn
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap <= '0;
    end else if (w_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1))) begin
      r_snap.value <= value;
      r_snap.point <= point_mask;
      r_snap.lz    <= lz_blank;
    end
  end

  // Next output values from the current slot state and snapshot
  always_comb begin
    w_upper = '0;
    w_blank = 1'b0;
    w_data  = '0;
    w_point = 1'b1;
    w_an    = ANODE_OFF;

    // Digits idx..3 are all zero exactly when the value shifted down by idx nibbles is zero
    w_upper = r_snap.value >> {r_idx, 2'b00};
    w_blank = r_snap.lz && (r_idx != '0) && (w_upper == '0);

    w_data  = nibble_sel(r_snap.value, r_idx);
    w_point = SEG_ACTIVE_LOW ? ~r_snap.point[r_idx] : r_snap.point[r_idx];
    if (!(w_guard || w_blank)) begin
      w_an = ~(NUM_DIGITS'(1) << r_idx);
    end
  end

  // Registered decoder and anode drive
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_point <= 1'b1;
      r_an    <= ANODE_OFF;
    end else begin
      r_data  <= w_data;
      r_point <= w_point;
      r_an    <= w_an;
    end
  end

  assign data  = r_data;
  assign point = r_point;
  assign an    = r_an;

endmodule

// File: doc/display_scan_mux.md
# display_scan_mux

Time-multiplexes a 4-digit, 16-bit value onto one shared 7-segment decoder and four common-anode digit enables. Sits directly upstream of the hex segment decoder. Its `data` and `point` outputs drive the decoder's `data[3:0]` and `point` inputs. Its `an` outputs drive the digit transistors. It adds per-frame snapshotting, anti-ghosting guard time and optional leading-zero blanking.

## Interface
Parameters:
- `REFRESH_DIV`, 50000: clock cycles per digit slot; must be ≥ 2 (50 MHz gives 1 kHz per digit).
- `GUARD_CYCLES`, 500: cycles at the start of each slot during which all anodes are off; must be < `REFRESH_DIV` (0 allowed).

Ports:
- `clk` in 1: single clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `value` in 16: four hex digits; digit i is `value[4i+3:4i]`; digit 0 is rightmost.
- `point_mask` in 4: bit i = 1 lights the decimal point of digit i.
- `lz_blank` in 1: 1 enables leading-zero blanking.
- `data` out 4: nibble of the active digit, to the decoder.
- `point` out 1: decimal point to the decoder, active-low (0 = lit).
- `an` out 4: digit enables, active-low; at most one bit is 0 at any time.

## Operation
- State:
  - slot counter `cnt`, 0..REFRESH_DIV-1
  - digit index `idx`, 0..3
  - snapshot registers `snap_value`, `snap_point`, `snap_lz`
- Counter behaviour:
  - `cnt` increments every cycle.
  - When `cnt` == REFRESH_DIV-1, `cnt` returns to 0 and `idx` advances.
  - `idx` wraps 3 → 0.
- Snapshot: loaded from `value`, `point_mask`, `lz_blank` on the cycle where `cnt` == REFRESH_DIV-1 and `idx` == 3. This is the last cycle of a frame. Input changes mid-frame never tear a frame.
- Slot phases for the current `idx`:
  - GUARD while `cnt` < GUARD_CYCLES.
  - ON otherwise.
- Blank condition for digit i:
  - Digit i (i = 1..3) is blank iff `snap_lz` = 1 and `snap_value` nibbles i..3 are all zero.
  - Digit 0 is never blank, so value 0 shows "0".
- Output registers, updated every cycle from the current `cnt`, `idx` and snapshot:
  - `data` = `snap_value` nibble `idx`.
  - `point` = ~`snap_point[idx]`.
  - `an` = 4'b1111 if GUARD or blank; otherwise all ones except bit `idx` = 0.
- Nibble value is not altered by blanking; only `an` suppresses the digit.

## Timing
- Reset values:
  - `cnt` = 0, `idx` = 0.
  - `snap_value` = 0, `snap_point` = 0, `snap_lz` = 0.
  - `data` = 4'h0, `point` = 1, `an` = 4'b1111.
- Outputs lag internal state by exactly one cycle, for example:
  - `an` goes all-high on the cycle after `cnt` = 0.
  - `an` goes low on the cycle after `cnt` = GUARD_CYCLES.
- Input-to-display latency: an input held from before the frame-end cycle reaches `data` for digit 0 one cycle after the next `idx` = 0 slot begins. Worst case is 4·REFRESH_DIV + 1 cycles.
- Reset asserted mid-slot: all state returns to reset values on the next edge, and `an` = 4'b1111 the cycle after.
- The first frame after reset displays snapshot 0, so digit 0 shows "0" with other digits lit as zeros, because `snap_lz` = 0.
- `GUARD_CYCLES` = 0: the digit is enabled one cycle after its slot starts; no all-off gap exists.
- An input change on the snapshot cycle itself is captured, with the new value.

## Structure
- Shared package `display_pkg`:
  - `NUM_DIGITS` = 4
  - `ANODE_OFF` = 4'b1111
  - `SEG_ACTIVE_LOW` = 1
  - function `nibble_sel(value, idx)`
- Sub-module `display_refresh_counter`:
  - Parameterised by `REFRESH_DIV`.
  - Outputs `cnt` and a one-cycle `slot_end` strobe.
  - `display_scan_mux` owns `idx`, the snapshot and the output logic.

## Test plan
All scenarios use `REFRESH_DIV` = 8, `GUARD_CYCLES` = 2.
- Reset:
  - Stimulus: hold `rst` 3 cycles with `value` = 16'h1234.
  - Response: `an` = 1111, `point` = 1, `data` = 0.
  - After release, the first frame shows nibbles 0,0,0,0 and the frame after shows 4,3,2,1 with `an` = 1110, 1101, 1011, 0111 in turn.
- Guard:
  - Response: in every slot, `an` = 1111 for the first 2 output cycles, then one-hot-low for 6.
  - Never more than one `an` bit low.
- Blanking:
  - Stimulus: `value` = 16'h0050, `lz_blank` = 1.
  - Response: digits 3 and 2 keep `an` = 1111 throughout their slots.
  - Digits 1 and 0 are lit with `data` 5 and 0.
  - Stimulus: `value` = 0.
  - Response: only digit 0 lights.
- Snapshot:
  - Stimulus: change `value` 16'hAAAA → 16'h5555 during the `idx` = 1 slot.
  - Response: that frame shows A on all digits; the next frame shows 5.
- Points:
  - Stimulus: `point_mask` = 4'b0100.
  - Response: `point` = 0 only while `idx` = 2.
- Mid-slot reset:
  - Stimulus: pulse `rst` for 1 cycle at `cnt` = 5, `idx` = 2.
  - Response: `an` = 1111 the next cycle.
  - Scanning restarts at `idx` = 0 with `cnt` = 0.
